// File: rtl/event_write_arbiter_pkg.sv
// Shared types for event_write_arbiter: FSM states, header magic and header word layout.
// HEADER state exists only when EVENT_WRITE_HEADER_EN is defined.
package event_write_arbiter_pkg;

    localparam logic [7:0] HEADER_MAGIC = 8'hA5;

`ifdef EVENT_WRITE_HEADER_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_HEADER,
        S_GRANT,
        S_RELEASE
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_RELEASE
    } state_t;
`endif

    typedef struct packed {
        logic [7:0]  magic;
        logic [3:0]  rsvd;
        logic [3:0]  src_id;
        logic [15:0] pad;
        logic [31:0] event_cnt;
    } header_t;

    function automatic header_t make_header(input logic [3:0] src_id, input logic [31:0] event_cnt);
        header_t h;
        h.magic     = HEADER_MAGIC;
        h.rsvd      = 4'h0;
        h.src_id    = src_id;
        h.pad       = 16'h0000;
        h.event_cnt = event_cnt;
        return h;
    endfunction

endpackage

// File: rtl/event_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after i_ptr wins.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_valid
);

    logic [PTR_W-1:0] w_k;

    always_comb begin
        o_gnt   = '0;
        o_valid = 1'b0;
        w_k     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            w_k = PTR_W'((i + int'(i_ptr)) % N);
            if (!o_valid && i_req[w_k]) begin
                o_gnt[w_k] = 1'b1;
                o_valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_write_arbiter.sv
// Arbitrates N_SRC event_saver sources onto one registered FIFO write port.
// Define EVENT_WRITE_HEADER_EN to prepend a header word to each granted burst.
module event_write_arbiter
    import event_write_arbiter_pkg::*;
#(
    parameter int unsigned N_SRC       = 4,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [N_SRC-1:0]       req_i,
    input  logic [N_SRC-1:0]       wr_en_i,
    input  logic [N_SRC-1:0][63:0] din_i,
    input  logic [N_SRC-1:0]       done_i,
    input  logic                   full_i,
    output logic [N_SRC-1:0]       grant_o,
    output logic                   wr_en_o,
    output logic [63:0]            din_o,
    output logic [15:0]            drop_cnt_o,
    output logic                   timeout_o
);

    localparam int unsigned PTR_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    state_t           r_state,   w_state_nxt;
    logic [N_SRC-1:0] r_grant,   w_grant_nxt;
    logic             r_wr_en,   w_wr_en_nxt;
    logic [63:0]      r_din,     w_din_nxt;
    logic [15:0]      r_drop,    w_drop_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic [CNT_W-1:0] r_cnt,     w_cnt_nxt;
    logic [PTR_W-1:0] r_src,     w_src_nxt;
    logic [PTR_W-1:0] r_rr_ptr,  w_ptr_nxt;
    logic [31:0]      r_event_cnt, w_evt_nxt;

    logic [N_SRC-1:0] w_arb_gnt;
    logic             w_arb_valid;
    logic [PTR_W-1:0] w_arb_ptr;
    logic [PTR_W-1:0] w_win_idx;
    logic [PTR_W-1:0] w_src_inc;
    logic [N_SRC-1:0] w_src_oh;

    assign w_src_inc = (r_src == PTR_W'(N_SRC - 1)) ? '0 : r_src + 1'b1;
    assign w_src_oh  = N_SRC'(1) << r_src;
    // RELEASE arbitrates with the already-advanced pointer so the grant gap is one cycle.
    assign w_arb_ptr = (r_state == S_RELEASE) ? w_src_inc : r_rr_ptr;

    rr_arbiter #(
        .N     (N_SRC),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .i_req   (req_i),
        .i_ptr   (w_arb_ptr),
        .o_gnt   (w_arb_gnt),
        .o_valid (w_arb_valid)
    );

    always_comb begin
        w_win_idx = '0;
        for (int unsigned i = 0; i < N_SRC; i++) begin
            if (w_arb_gnt[i]) w_win_idx = PTR_W'(i);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_wr_en_nxt   = 1'b0;
        w_din_nxt     = r_din;
        w_drop_nxt    = r_drop;
        w_timeout_nxt = 1'b0;
        w_cnt_nxt     = r_cnt;
        w_src_nxt     = r_src;
        w_ptr_nxt     = r_rr_ptr;
        w_evt_nxt     = r_event_cnt;

        case (r_state)
            S_IDLE, S_RELEASE: begin
                if (r_state == S_RELEASE) begin
                    w_grant_nxt = '0;
                    w_ptr_nxt   = w_src_inc;
                    w_evt_nxt   = r_event_cnt + 32'd1;
                    w_state_nxt = S_IDLE;
                end
                if (w_arb_valid) begin
                    w_src_nxt = w_win_idx;
                    w_cnt_nxt = '0;
`ifdef EVENT_WRITE_HEADER_EN
                    w_state_nxt = S_HEADER;
`else
                    w_state_nxt = S_GRANT;
                    w_grant_nxt = w_arb_gnt;
`endif
                end
            end
`ifdef EVENT_WRITE_HEADER_EN
            S_HEADER: begin
                if (!full_i) begin
                    w_wr_en_nxt = 1'b1;
                    w_din_nxt   = make_header(4'(r_src), r_event_cnt);
                    w_grant_nxt = w_src_oh;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_GRANT;
                end
            end
`endif
            S_GRANT: begin
                if (wr_en_i[r_src]) begin
                    if (full_i) begin
                        if (r_drop != 16'hFFFF) w_drop_nxt = r_drop + 16'd1;
                    end else begin
                        w_wr_en_nxt = 1'b1;
                        w_din_nxt   = din_i[r_src];
                    end
                end
                if (done_i[r_src]) begin
                    w_grant_nxt = '0;
                    w_state_nxt = S_RELEASE;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_grant_nxt   = '0;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_RELEASE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_wr_en     <= 1'b0;
            r_din       <= '0;
            r_drop      <= '0;
            r_timeout   <= 1'b0;
            r_cnt       <= '0;
            r_src       <= '0;
            r_rr_ptr    <= '0;
            r_event_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_din       <= w_din_nxt;
            r_drop      <= w_drop_nxt;
            r_timeout   <= w_timeout_nxt;
            r_cnt       <= w_cnt_nxt;
            r_src       <= w_src_nxt;
            r_rr_ptr    <= w_ptr_nxt;
            r_event_cnt <= w_evt_nxt;
        end
    end

    assign grant_o    = r_grant;
    assign wr_en_o    = r_wr_en;
    assign din_o      = r_din;
    assign drop_cnt_o = r_drop;
    assign timeout_o  = r_timeout;

endmodule
